pipe_cu: RTL and testbench
==========================

Name: pipe_cu

Overview:
- Pipelined control unit for the 5-stage RV32I core.
- Decodes the instruction in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers.
- Resolves all six branch conditions in EX from ALU flags.
- Inserts bubbles on flush, flags illegal opcodes, and counts retired instructions.

Parameters:
- WIDTH, 32: instruction width.
- ALU_CTRL_W, 4: width of alu_ctrl encoding.
- CNT_W, 32: width of retired-instruction counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- instr_d  in  WIDTH  instruction in ID stage
- flush_e  in  1  load bubble into ID/EX instead of decoded bundle (from hazard unit)
- zero_e  in  1  ALU result == 0 (EX)
- lt_e  in  1  signed rs1 < rs2 (EX)
- ltu_e  in  1  unsigned rs1 < rs2 (EX)
- imm_src_d  out  3  immediate format for extender: 0 I, 1 S, 2 B, 3 U, 4 J
- illegal_d  out  1  unsupported opcode/funct in ID
- alu_ctrl_e  out  ALU_CTRL_W  ALU operation
- alu_src_e  out  1  1 = immediate operand B
- alu_a_pc_e  out  1  1 = PC as operand A (AUIPC)
- jalr_e  out  1  branch target taken from ALU result
- pc_src_e  out  1  redirect PC this cycle
- load_e  out  1  EX holds a load (load-use detection)
- mem_write_m  out  1  store enable
- funct3_m  out  3  access size/sign for LSU
- reg_write_m  out  1  forwarding qualifier
- reg_write_w  out  1  register file write enable
- result_src_w  out  2  0 ALU, 1 memory, 2 PC+4
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Decode (combinational, ID). Opcodes:
  - 0110011 R
  - 0010011 I-ALU
  - 0000011 load
  - 0100011 store
  - 1100011 branch
  - 1101111 JAL
  - 1100111 JALR
  - 0110111 LUI
  - 0010111 AUIPC
- Any other opcode, or branch funct3 010/011, sets illegal_d=1. The decoded bundle then has reg_write, mem_write, branch and jump at 0 and valid at 0.
- alu_ctrl encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 PASSB.
  - R-type: SUB when funct7[5]=1 and funct3=000. SRA when funct7[5]=1 and funct3=101.
  - I-ALU: funct3 101 with funct7[5]=1 gives SRA. funct3 000 is always ADD.
  - Loads, stores, JALR, AUIPC use ADD. Branches use SUB. LUI uses PASSB.
- ID/EX register, on each clk edge:
  - flush_e=1: load bubble (all enables 0, valid 0, alu_ctrl 0).
  - Otherwise: load the decoded bundle.
- EX/MEM and MEM/WB registers advance every cycle; there is no stall at those stages.
- Latency: instruction in ID at cycle N. Its EX outputs are valid in N+1, MEM outputs in N+2, WB outputs in N+3.
- pc_src_e is combinational: jump_e | (branch_e & cond).
  - cond by funct3_e: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
  - A bubble in EX never asserts pc_src_e.
- instret increments by 1 on a clk edge when the MEM/WB valid bit is 1. It wraps from 2^CNT_W-1 to 0 with no flag.
- rst_n low, asynchronous: all pipeline registers take the bubble value and instret goes to 0. As a result these outputs read 0:
  - alu_ctrl_e, alu_src_e, alu_a_pc_e, jalr_e, pc_src_e, load_e, mem_write_m, funct3_m, reg_write_m, reg_write_w, result_src_w.
- Reset mid-operation discards all in-flight bundles.
- Deassertion takes effect at the next clk edge.
- Flush and illegal together still produce a bubble.

Test Plan:
- Reset: hold rst_n=0, drive add x1,x2,x3 (0x003100B3) -> every EX/MEM/WB output 0 and instret=0. Release reset -> reg_write_w=1 and result_src_w=0 three cycles later.
- Back-to-back add, sub, lw, sw -> alu_ctrl_e sequence 0, 1, 0, 0. result_src_w=1 only for lw. mem_write_m=1 only for sw. instret reaches 4.
- Branch sweep, funct3 000/001/100/101/110/111:
  - zero_e=1, lt_e=0, ltu_e=1 -> pc_src_e = 1, 0, 0, 1, 1, 0.
  - jal -> pc_src_e=1 and result_src_w=2.
  - jalr -> pc_src_e=1 and jalr_e=1.
- flush_e=1 while a sw is in ID -> mem_write_m stays 0 and instret does not increment for it.
- Illegal opcode 0x0000007F -> illegal_d=1 and no write enables downstream. Branch funct3 010 -> illegal_d=1.
- Counter wrap: CNT_W=4 with 17 valid instructions -> instret reads 1.

Source files
------------

// File: rtl/pipe_cu.sv
// rtl/pipe_cu.sv - RV32I pipelined control unit: ID decode, ID/EX/MEM/WB control registers, branch resolve, retire counter
//
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   instr_d               instruction currently in ID
//   flush_e               replace the ID/EX load with a bubble
//   zero_e, lt_e, ltu_e   ALU comparison flags for the instruction in EX
//   imm_src_d, illegal_d  ID-stage decode outputs
//   alu_ctrl_e .. load_e  EX-stage controls; pc_src_e is the resolved redirect
//   mem_write_m, funct3_m, reg_write_m   MEM-stage controls
//   reg_write_w, result_src_w            WB-stage controls
//   instret               count of instructions that left WB

module pipe_cu #(
    parameter int WIDTH      = 32,
    parameter int ALU_CTRL_W = 4,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      instr_d,
    input  logic                  flush_e,
    input  logic                  zero_e,
    input  logic                  lt_e,
    input  logic                  ltu_e,
    output logic [2:0]            imm_src_d,
    output logic                  illegal_d,
    output logic [ALU_CTRL_W-1:0] alu_ctrl_e,
    output logic                  alu_src_e,
    output logic                  alu_a_pc_e,
    output logic                  jalr_e,
    output logic                  pc_src_e,
    output logic                  load_e,
    output logic                  mem_write_m,
    output logic [2:0]            funct3_m,
    output logic                  reg_write_m,
    output logic                  reg_write_w,
    output logic [1:0]            result_src_w,
    output logic [CNT_W-1:0]      instret
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD   = ALU_CTRL_W'(0);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB   = ALU_CTRL_W'(1);
    localparam logic [ALU_CTRL_W-1:0] ALU_AND   = ALU_CTRL_W'(2);
    localparam logic [ALU_CTRL_W-1:0] ALU_OR    = ALU_CTRL_W'(3);
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR   = ALU_CTRL_W'(4);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT   = ALU_CTRL_W'(5);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU  = ALU_CTRL_W'(6);
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL   = ALU_CTRL_W'(7);
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL   = ALU_CTRL_W'(8);
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA   = ALU_CTRL_W'(9);
    localparam logic [ALU_CTRL_W-1:0] ALU_PASSB = ALU_CTRL_W'(10);

    // Control bundle held in ID/EX; an all-zero value is the bubble.
    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic [1:0]            result_src;
        logic                  mem_write;
        logic                  branch;
        logic                  jump;
        logic                  jalr;
        logic [ALU_CTRL_W-1:0] alu_ctrl;
        logic                  alu_src;
        logic                  alu_a_pc;
        logic                  load;
        logic [2:0]            funct3;
    } ctrl_t;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_funct7b5;
    logic       w_unused_instr;
    ctrl_t      w_dec;
    logic [2:0] w_imm_src;
    logic       w_illegal;
    logic       w_cond;

    ctrl_t      r_ex;
    logic       r_m_valid;
    logic       r_m_reg_write;
    logic [1:0] r_m_result_src;
    logic       r_m_mem_write;
    logic [2:0] r_m_funct3;
    logic       r_w_valid;
    logic       r_w_reg_write;
    logic [1:0] r_w_result_src;
    logic [CNT_W-1:0] r_instret;

    assign w_opcode       = instr_d[6:0];
    assign w_funct3       = instr_d[14:12];
    assign w_funct7b5     = instr_d[30];
    assign w_unused_instr = ^{instr_d[WIDTH-1:31], instr_d[29:15], instr_d[11:7]};

    // Shared R/I arithmetic decode; only R-type may select SUB via funct7[5].
    function automatic logic [ALU_CTRL_W-1:0] alu_op(input logic [2:0] f3,
                                                     input logic       f7b5,
                                                     input logic       is_r);
        logic [ALU_CTRL_W-1:0] op;
        case (f3)
            3'b000:  op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        w_dec     = '0;
        w_imm_src = IMM_I;
        w_illegal = 1'b0;
        case (w_opcode)
            OP_R: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_ctrl  = alu_op(w_funct3, w_funct7b5, 1'b1);
            end
            OP_I: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.alu_ctrl  = alu_op(w_funct3, w_funct7b5, 1'b0);
            end
            OP_LOAD: begin
                w_dec.reg_write  = 1'b1;
                w_dec.result_src = 2'd1;
                w_dec.alu_src    = 1'b1;
                w_dec.load       = 1'b1;
            end
            OP_STORE: begin
                w_imm_src       = IMM_S;
                w_dec.mem_write = 1'b1;
                w_dec.alu_src   = 1'b1;
            end
            OP_BRANCH: begin
                // funct3 010/011 have no branch meaning in RV32I
                if (w_funct3[2:1] == 2'b01) begin
                    w_illegal = 1'b1;
                end else begin
                    w_imm_src      = IMM_B;
                    w_dec.branch   = 1'b1;
                    w_dec.alu_ctrl = ALU_SUB;
                end
            end
            OP_JAL: begin
                w_imm_src        = IMM_J;
                w_dec.reg_write  = 1'b1;
                w_dec.result_src = 2'd2;
                w_dec.jump       = 1'b1;
            end
            OP_JALR: begin
                w_dec.reg_write  = 1'b1;
                w_dec.result_src = 2'd2;
                w_dec.jump       = 1'b1;
                w_dec.jalr       = 1'b1;
                w_dec.alu_src    = 1'b1;
            end
            OP_LUI: begin
                w_imm_src       = IMM_U;
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.alu_ctrl  = ALU_PASSB;
            end
            OP_AUIPC: begin
                w_imm_src       = IMM_U;
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = 1'b1;
                w_dec.alu_a_pc  = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
        // Illegal instructions stay an all-zero (bubble) bundle.
        if (!w_illegal) begin
            w_dec.valid  = 1'b1;
            w_dec.funct3 = w_funct3;
        end
    end

    assign imm_src_d = w_imm_src;
    assign illegal_d = w_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex <= '0;
        end else if (flush_e) begin
            r_ex <= '0;
        end else begin
            r_ex <= w_dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid      <= 1'b0;
            r_m_reg_write  <= 1'b0;
            r_m_result_src <= 2'd0;
            r_m_mem_write  <= 1'b0;
            r_m_funct3     <= 3'd0;
            r_w_valid      <= 1'b0;
            r_w_reg_write  <= 1'b0;
            r_w_result_src <= 2'd0;
            r_instret      <= '0;
        end else begin
            r_m_valid      <= r_ex.valid;
            r_m_reg_write  <= r_ex.reg_write;
            r_m_result_src <= r_ex.result_src;
            r_m_mem_write  <= r_ex.mem_write;
            r_m_funct3     <= r_ex.funct3;
            r_w_valid      <= r_m_valid;
            r_w_reg_write  <= r_m_reg_write;
            r_w_result_src <= r_m_result_src;
            if (r_w_valid) begin
                r_instret <= r_instret + CNT_W'(1);
            end
        end
    end

    // Branch compares run as SUB, so zero_e means rs1 == rs2.
    always_comb begin
        w_cond = 1'b0;
        case (r_ex.funct3)
            3'b000:  w_cond = zero_e;
            3'b001:  w_cond = ~zero_e;
            3'b100:  w_cond = lt_e;
            3'b101:  w_cond = ~lt_e;
            3'b110:  w_cond = ltu_e;
            3'b111:  w_cond = ~ltu_e;
            default: w_cond = 1'b0;
        endcase
    end

    assign pc_src_e     = r_ex.jump | (r_ex.branch & w_cond);
    assign alu_ctrl_e   = r_ex.alu_ctrl;
    assign alu_src_e    = r_ex.alu_src;
    assign alu_a_pc_e   = r_ex.alu_a_pc;
    assign jalr_e       = r_ex.jalr;
    assign load_e       = r_ex.load;
    assign mem_write_m  = r_m_mem_write;
    assign funct3_m     = r_m_funct3;
    assign reg_write_m  = r_m_reg_write;
    assign reg_write_w  = r_w_reg_write;
    assign result_src_w = r_w_result_src;
    assign instret      = r_instret;

endmodule

// File: tb/tb_pipe_cu.sv
// tb/tb_pipe_cu.sv - scoreboard bench for pipe_cu with directed instruction vectors

module tb_pipe_cu;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr_d;
    logic        flush_e;
    logic        zero_e, lt_e, ltu_e;
    logic [2:0]  imm_src_d;
    logic        illegal_d;
    logic [3:0]  alu_ctrl_e;
    logic        alu_src_e, alu_a_pc_e, jalr_e, pc_src_e, load_e;
    logic        mem_write_m;
    logic [2:0]  funct3_m;
    logic        reg_write_m, reg_write_w;
    logic [1:0]  result_src_w;
    logic [31:0] instret;

    logic [2:0]  d4_unused_imm;
    logic        d4_unused_ill;
    logic [3:0]  d4_unused_alu;
    logic        d4_unused_asrc, d4_unused_apc, d4_unused_jalr, d4_unused_pcs, d4_unused_load;
    logic        d4_unused_mw;
    logic [2:0]  d4_unused_f3;
    logic        d4_unused_rwm, d4_unused_rww;
    logic [1:0]  d4_unused_rs;
    logic [3:0]  instret4;

    pipe_cu u_dut (
        .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .flush_e(flush_e),
        .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
        .imm_src_d(imm_src_d), .illegal_d(illegal_d), .alu_ctrl_e(alu_ctrl_e),
        .alu_src_e(alu_src_e), .alu_a_pc_e(alu_a_pc_e), .jalr_e(jalr_e),
        .pc_src_e(pc_src_e), .load_e(load_e), .mem_write_m(mem_write_m),
        .funct3_m(funct3_m), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .result_src_w(result_src_w), .instret(instret)
    );

    pipe_cu #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .flush_e(flush_e),
        .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
        .imm_src_d(d4_unused_imm), .illegal_d(d4_unused_ill), .alu_ctrl_e(d4_unused_alu),
        .alu_src_e(d4_unused_asrc), .alu_a_pc_e(d4_unused_apc), .jalr_e(d4_unused_jalr),
        .pc_src_e(d4_unused_pcs), .load_e(d4_unused_load), .mem_write_m(d4_unused_mw),
        .funct3_m(d4_unused_f3), .reg_write_m(d4_unused_rwm), .reg_write_w(d4_unused_rww),
        .result_src_w(d4_unused_rs), .instret(instret4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected response for one instruction; exb = {alu_src, alu_a_pc, jalr, pc_src, load}
    typedef struct {
        logic [2:0] imm;
        logic       ill;
        logic [3:0] alu;
        logic [4:0] exb;
        logic       mw;
        logic [2:0] f3;
        logic       rw;
        logic [1:0] rs;
        logic       vld;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        bub;
    exp_t        s_ex, s_m, s_w;
    logic [31:0] exp_instret;
    logic        running;
    logic        rst_req;
    logic [2:0]  prev_flags;
    int          checks;
    int          errors;

    localparam logic [31:0] NOP = 32'h00000013;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one instruction into ID for one cycle; flags flg belong to this
    // instruction's EX cycle and are therefore applied on the following issue.
    task automatic issue(input logic [31:0] ins, input logic fl, input logic [2:0] flg,
                         input logic [2:0] imm, input logic ill, input logic [3:0] alu,
                         input logic [4:0] exb, input logic mw, input logic [2:0] f3,
                         input logic rw, input logic [1:0] rs, input logic vld);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n   = rst_req;
        instr_d = ins;
        flush_e = fl;
        {zero_e, lt_e, ltu_e} = prev_flags;
        prev_flags = flg;
        e.imm = imm; e.ill = ill; e.alu = alu; e.exb = exb; e.mw = mw;
        e.f3 = f3; e.rw = rw; e.rs = rs; e.vld = vld;
        exp_q.push_back(e);
        running = 1'b1;
    endtask

    task automatic idle();
        issue(NOP, 1'b1, 3'b000, 3'd0, 1'b0, 4'd0, 5'b00000, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic add_op();
        issue(32'h003100B3, 1'b0, 3'b000, 3'd0, 1'b0, 4'd0, 5'b00000, 1'b0, 3'd0, 1'b1, 2'd0, 1'b1);
    endtask

    // Monitor: pops the record entering ID and keeps its own EX/MEM/WB history.
    always @(negedge clk) begin : monitor
        exp_t cur;
        if (running) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow got empty expected record at %0t", $time);
                cur = bub;
            end else begin
                cur = exp_q.pop_front();
            end
            if (!rst_n) begin
                s_ex = bub; s_m = bub; s_w = bub;
                exp_instret = 0;
            end
            chk("imm_src_d",    {29'd0, imm_src_d},   {29'd0, cur.imm});
            chk("illegal_d",    {31'd0, illegal_d},   {31'd0, cur.ill});
            chk("alu_ctrl_e",   {28'd0, alu_ctrl_e},  {28'd0, s_ex.alu});
            chk("ex_ctrls",     {27'd0, alu_src_e, alu_a_pc_e, jalr_e, pc_src_e, load_e},
                                {27'd0, s_ex.exb});
            chk("mem_write_m",  {31'd0, mem_write_m}, {31'd0, s_m.mw});
            chk("funct3_m",     {29'd0, funct3_m},    {29'd0, s_m.f3});
            chk("reg_write_m",  {31'd0, reg_write_m}, {31'd0, s_m.rw});
            chk("reg_write_w",  {31'd0, reg_write_w}, {31'd0, s_w.rw});
            chk("result_src_w", {30'd0, result_src_w}, {30'd0, s_w.rs});
            chk("instret",      instret, exp_instret);
            chk("instret4",     {28'd0, instret4}, {28'd0, exp_instret[3:0]});
            if (rst_n && s_w.vld) exp_instret = exp_instret + 1;
            s_w = s_m; s_m = s_ex; s_ex = cur;
            if (!rst_n) begin
                s_ex = bub; s_m = bub; s_w = bub;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got no finish expected finish by 100000");
        $fatal(1);
    end

    initial begin
        bub = '{imm: 3'd0, ill: 1'b0, alu: 4'd0, exb: 5'd0, mw: 1'b0, f3: 3'd0,
                rw: 1'b0, rs: 2'd0, vld: 1'b0};
        s_ex = bub; s_m = bub; s_w = bub;
        exp_instret = 0;
        checks = 0; errors = 0;
        running = 1'b0;
        rst_req = 1'b0;
        prev_flags = 3'b000;
        rst_n = 1'b0; instr_d = 32'd0; flush_e = 1'b0;
        zero_e = 1'b0; lt_e = 1'b0; ltu_e = 1'b0;
        repeat (2) @(posedge clk);

        // reset held with add in ID, then released
        add_op();
        add_op();
        rst_req = 1'b1;
        add_op();
        idle(); idle(); idle();

        // add, sub, lw, sw back to back
        add_op();
        issue(32'h403100B3, 1'b0, 3'b000, 3'd0, 1'b0, 4'd1, 5'b00000, 1'b0, 3'd0, 1'b1, 2'd0, 1'b1);
        issue(32'h00012083, 1'b0, 3'b000, 3'd0, 1'b0, 4'd0, 5'b10001, 1'b0, 3'd2, 1'b1, 2'd1, 1'b1);
        issue(32'h00112023, 1'b0, 3'b000, 3'd1, 1'b0, 4'd0, 5'b10000, 1'b1, 3'd2, 1'b0, 2'd0, 1'b1);
        idle(); idle(); idle();

        // branch sweep with zero=1, lt=0, ltu=1
        issue(32'h00208063, 1'b0, 3'b101, 3'd2, 1'b0, 4'd1, 5'b00010, 1'b0, 3'd0, 1'b0, 2'd0, 1'b1);
        issue(32'h00209063, 1'b0, 3'b101, 3'd2, 1'b0, 4'd1, 5'b00000, 1'b0, 3'd1, 1'b0, 2'd0, 1'b1);
        issue(32'h0020C063, 1'b0, 3'b101, 3'd2, 1'b0, 4'd1, 5'b00000, 1'b0, 3'd4, 1'b0, 2'd0, 1'b1);
        issue(32'h0020D063, 1'b0, 3'b101, 3'd2, 1'b0, 4'd1, 5'b00010, 1'b0, 3'd5, 1'b0, 2'd0, 1'b1);
        issue(32'h0020E063, 1'b0, 3'b101, 3'd2, 1'b0, 4'd1, 5'b00010, 1'b0, 3'd6, 1'b0, 2'd0, 1'b1);
        issue(32'h0020F063, 1'b0, 3'b101, 3'd2, 1'b0, 4'd1, 5'b00000, 1'b0, 3'd7, 1'b0, 2'd0, 1'b1);
        // opposite flags: blt and bgeu taken with zero=0, lt=1, ltu=0
        issue(32'h0020C063, 1'b0, 3'b010, 3'd2, 1'b0, 4'd1, 5'b00010, 1'b0, 3'd4, 1'b0, 2'd0, 1'b1);
        issue(32'h0020F063, 1'b0, 3'b010, 3'd2, 1'b0, 4'd1, 5'b00010, 1'b0, 3'd7, 1'b0, 2'd0, 1'b1);
        // jal, jalr
        issue(32'h000000EF, 1'b0, 3'b000, 3'd4, 1'b0, 4'd0, 5'b00010, 1'b0, 3'd0, 1'b1, 2'd2, 1'b1);
        issue(32'h000100E7, 1'b0, 3'b000, 3'd0, 1'b0, 4'd0, 5'b10110, 1'b0, 3'd0, 1'b1, 2'd2, 1'b1);

        // flushed store, illegal opcode, illegal branch funct3, flush with illegal
        issue(32'h00112023, 1'b1, 3'b000, 3'd1, 1'b0, 4'd0, 5'b00000, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0);
        issue(32'h0000007F, 1'b0, 3'b000, 3'd0, 1'b1, 4'd0, 5'b00000, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0);
        issue(32'h0020A063, 1'b0, 3'b000, 3'd0, 1'b1, 4'd0, 5'b00000, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0);
        issue(32'h0000007F, 1'b1, 3'b000, 3'd0, 1'b1, 4'd0, 5'b00000, 1'b0, 3'd0, 1'b0, 2'd0, 1'b0);

        // srai, addi with bit30 set, sra, lui, auipc
        issue(32'h40315093, 1'b0, 3'b000, 3'd0, 1'b0, 4'd9,  5'b10000, 1'b0, 3'd5, 1'b1, 2'd0, 1'b1);
        issue(32'h40010093, 1'b0, 3'b000, 3'd0, 1'b0, 4'd0,  5'b10000, 1'b0, 3'd0, 1'b1, 2'd0, 1'b1);
        issue(32'h403150B3, 1'b0, 3'b000, 3'd0, 1'b0, 4'd9,  5'b00000, 1'b0, 3'd5, 1'b1, 2'd0, 1'b1);
        issue(32'h000100B7, 1'b0, 3'b000, 3'd3, 1'b0, 4'd10, 5'b10000, 1'b0, 3'd0, 1'b1, 2'd0, 1'b1);
        issue(32'h00000097, 1'b0, 3'b000, 3'd3, 1'b0, 4'd0,  5'b11000, 1'b0, 3'd0, 1'b1, 2'd0, 1'b1);

        // reset while instructions are in flight, then 17 adds for the wrap
        add_op();
        add_op();
        rst_req = 1'b0;
        add_op();
        add_op();
        rst_req = 1'b1;
        for (int i = 0; i < 17; i++) add_op();
        idle(); idle(); idle(); idle();

        @(negedge clk);
        #1;
        running = 1'b0;
        chk("instret_final", instret, 32'd17);
        chk("instret4_wrap", {28'd0, instret4}, 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
